// File: rtl/trap_pkg.sv
// Shared types and constants for the trap/interrupt controller.
// mcause encoding helpers live here so the top and any CSR-side decoder agree.
package trap_pkg;

    typedef enum logic {
        TRAP_IDLE,
        TRAP_ACTIVE
    } trap_state_t;

    localparam int MCAUSE_INT_BIT = 31;
    localparam int DEF_ECALL_CODE = 11;
    localparam int DEF_IRQ_BASE   = 16;

    // Interrupt cause: code in the low bits, interrupt flag in bit 31.
    function automatic logic [31:0] irq_cause(input int unsigned base, input int unsigned idx);
        logic [31:0] c;
        c                 = 32'(base + idx);
        c[MCAUSE_INT_BIT] = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Fixed-priority encoder: the lowest set request bit wins.
// Purely combinational; idx/onehot are zero when no request is set.
module trap_prio_enc #(
    parameter  int N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    // NOTE: every output gets a default before the loop so no latch is inferred.
    always_comb begin
        valid  = |req;
        idx    = '0;
        onehot = '0;
        // Scan high to low so the last hit written is the lowest index.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx       = IW'(i);
                onehot    = '0;
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_irq_ctrl.sv
// Trap/interrupt controller: ecall plus N_IRQ prioritised, maskable lines.
// Drives trap entry/return pulses to Fetch and the trap cause to CSR.
module trap_irq_ctrl
    import trap_pkg::*;
#(
    parameter int               N_IRQ      = 8,
    parameter logic [N_IRQ-1:0] EDGE_MASK  = '0,
    parameter int               IRQ_BASE   = DEF_IRQ_BASE,
    parameter int               ECALL_CODE = DEF_ECALL_CODE
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             hold,
    input  logic             ecall,
    input  logic             trap_ret,
    input  logic [N_IRQ-1:0] irq,
    input  logic [N_IRQ-1:0] irq_en,
    input  logic             gie,
    output logic             trapping,
    output logic             trigger_trap,
    output logic             trigger_trap_ret,
    output logic [31:0]      mcause,
    output logic [N_IRQ-1:0] irq_pending,
    output logic [N_IRQ-1:0] irq_claim
);

    localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

    trap_state_t      r_state;
    trap_state_t      w_next_state;
    logic [N_IRQ-1:0] r_irq_d;
    logic [N_IRQ-1:0] r_edge_pend;
    logic [N_IRQ-1:0] w_req;
    logic [N_IRQ-1:0] w_onehot;
    logic [N_IRQ-1:0] w_claim;
    logic [IW-1:0]    w_idx;
    logic             w_valid;
    logic             w_take_trap;
    logic             w_take_ret;
    logic             r_trigger_trap;
    logic             r_trigger_trap_ret;
    logic [31:0]      r_mcause;
    logic [N_IRQ-1:0] r_irq_claim;

    // Level lines pass straight through; edge lines come from the latched flags.
    assign irq_pending = (EDGE_MASK & r_edge_pend) | (~EDGE_MASK & irq);
    assign w_req       = irq_pending & irq_en & {N_IRQ{gie}};

    trap_prio_enc #(.N(N_IRQ)) u_prio (
        .req    (w_req),
        .valid  (w_valid),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

    always_comb begin
        w_next_state = r_state;
        w_take_trap  = 1'b0;
        w_take_ret   = 1'b0;
        case (r_state)
            TRAP_IDLE: begin
                if (!hold && (ecall || w_valid)) begin
                    w_next_state = TRAP_ACTIVE;
                    w_take_trap  = 1'b1;
                end
            end
            TRAP_ACTIVE: begin
                if (!hold && trap_ret) begin
                    w_next_state = TRAP_IDLE;
                    w_take_ret   = 1'b1;
                end
            end
            default: w_next_state = TRAP_IDLE;
        endcase
    end

    // An ecall outranks interrupts, so no line is claimed on an ecall entry.
    assign w_claim = (w_take_trap && !ecall) ? w_onehot : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= TRAP_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Edge capture keeps running through hold and trap; a new edge beats a claim.
    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_irq_d     <= '0;
            r_edge_pend <= '0;
        end else begin
            r_irq_d     <= irq;
            r_edge_pend <= EDGE_MASK & ((r_edge_pend & ~w_claim) | (irq & ~r_irq_d));
        end
    end

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_trigger_trap     <= 1'b0;
            r_trigger_trap_ret <= 1'b0;
            r_irq_claim        <= '0;
            r_mcause           <= '0;
        end else begin
            r_trigger_trap     <= w_take_trap;
            r_trigger_trap_ret <= w_take_ret;
            r_irq_claim        <= w_claim;
            if (w_take_trap) begin
                r_mcause <= ecall ? 32'(ECALL_CODE)
                                  : irq_cause(IRQ_BASE, 32'(w_idx));
            end
        end
    end

    assign trapping         = (r_state == TRAP_ACTIVE);
    assign trigger_trap     = r_trigger_trap;
    assign trigger_trap_ret = r_trigger_trap_ret;
    assign mcause           = r_mcause;
    assign irq_claim        = r_irq_claim;

endmodule

// File: tb/tb_trap_irq_ctrl.sv
// Self-checking bench for trap_irq_ctrl: directed stimulus, with every trap
// entry checked against a queue of expected {mcause, claim} pairs.
module tb_trap_irq_ctrl;

    localparam int N = 8;

    logic         clk      = 1'b0;
    logic         Rst      = 1'b1;
    logic         hold     = 1'b0;
    logic         ecall    = 1'b0;
    logic         trap_ret = 1'b0;
    logic         gie      = 1'b0;
    logic [N-1:0] irq      = '0;
    logic [N-1:0] irq_en   = '0;

    logic         trapping;
    logic         trigger_trap;
    logic         trigger_trap_ret;
    logic [31:0]  mcause;
    logic [N-1:0] irq_pending;
    logic [N-1:0] irq_claim;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [31:0]  mcause;
        logic [N-1:0] claim;
    } exp_t;

    exp_t exp_q[$];

    trap_irq_ctrl #(
        .N_IRQ      (N),
        .EDGE_MASK  (8'h01),
        .IRQ_BASE   (16),
        .ECALL_CODE (11)
    ) dut (
        .clk              (clk),
        .Rst              (Rst),
        .hold             (hold),
        .ecall            (ecall),
        .trap_ret         (trap_ret),
        .irq              (irq),
        .irq_en           (irq_en),
        .gie              (gie),
        .trapping         (trapping),
        .trigger_trap     (trigger_trap),
        .trigger_trap_ret (trigger_trap_ret),
        .mcause           (mcause),
        .irq_pending      (irq_pending),
        .irq_claim        (irq_claim)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_trap(input logic [31:0] mc, input logic [N-1:0] cl);
        exp_t e;
        e.mcause = mc;
        e.claim  = cl;
        exp_q.push_back(e);
    endtask

    // {trapping, trigger_trap, trigger_trap_ret}
    function automatic logic [63:0] flags();
        return 64'({trapping, trigger_trap, trigger_trap_ret});
    endfunction

    task automatic check_all_zero(input string tag);
        check(tag, 64'({trapping, trigger_trap, trigger_trap_ret, irq_pending, irq_claim, mcause}), 64'd0);
    endtask

    // Scoreboard: every observed entry pulse consumes one expected entry.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!Rst && trigger_trap) begin
            if (exp_q.size() == 0) begin
                check("unexpected_trap", 64'(mcause), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_mcause", 64'(mcause), 64'(e.mcause));
                check("sb_claim", 64'(irq_claim), 64'(e.claim));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // 1. Reset, idle, and trap_ret ignored in IDLE.
        repeat (3) step();
        check_all_zero("rst_held");
        Rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            check_all_zero("idle_quiet");
        end
        trap_ret = 1'b1;
        step();
        check_all_zero("ret_in_idle");
        trap_ret = 1'b0;

        // 2. ecall entry and return five cycles later.
        ecall = 1'b1;
        expect_trap(32'd11, 8'h00);
        step();
        ecall = 1'b0;
        check("ecall_entry_flags", flags(), 64'b110);
        check("ecall_mcause", 64'(mcause), 64'd11);
        step();
        check("ecall_pulse_once", flags(), 64'b100);
        repeat (3) step();
        trap_ret = 1'b1;
        step();
        trap_ret = 1'b0;
        check("ecall_ret_flags", flags(), 64'b001);
        check("mcause_hold_ret", 64'(mcause), 64'd11);
        step();
        check("ret_pulse_once", flags(), 64'b000);

        // 3. Level lines 2 and 5: line 2 wins; ecall beats both.
        gie    = 1'b1;
        irq_en = 8'hFF;
        irq    = 8'b0010_0100;
        expect_trap(32'h8000_0012, 8'h04);
        step();
        check("irq2_flags", flags(), 64'b110);
        check("irq2_claim", 64'(irq_claim), 64'h04);
        irq      = '0;
        trap_ret = 1'b1;
        step();
        trap_ret = 1'b0;
        check("irq2_ret", flags(), 64'b001);
        irq   = 8'b0010_0100;
        ecall = 1'b1;
        expect_trap(32'd11, 8'h00);
        step();
        check("ecall_beats_irq", 64'(mcause), 64'd11);
        ecall    = 1'b0;
        irq      = '0;
        trap_ret = 1'b1;
        step();
        trap_ret = 1'b0;
        step();

        // 4. Edge line 0 pulsed while gie=0 stays pending, traps once gie=1.
        gie = 1'b0;
        irq = 8'h01;
        step();
        irq = '0;
        check("edge_pend_set", 64'(irq_pending), 64'h01);
        repeat (2) step();
        check("edge_pend_kept", 64'(irq_pending), 64'h01);
        check("edge_no_trap_gie0", flags(), 64'b000);
        gie = 1'b1;
        expect_trap(32'h8000_0010, 8'h01);
        step();
        check("edge_trap_flags", flags(), 64'b110);
        check("edge_pend_cleared", 64'(irq_pending), 64'h00);
        trap_ret = 1'b1;
        step();
        trap_ret = 1'b0;
        step();

        // 5. Hold defers both entry and return.
        hold  = 1'b1;
        ecall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_entry_blocked", flags(), 64'b000);
        end
        hold = 1'b0;
        expect_trap(32'd11, 8'h00);
        step();
        check("hold_release_entry", flags(), 64'b110);
        ecall    = 1'b0;
        hold     = 1'b1;
        trap_ret = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("hold_ret_blocked", flags(), 64'b100);
        end
        hold = 1'b0;
        step();
        check("hold_release_ret", flags(), 64'b001);
        trap_ret = 1'b0;
        step();

        // 6. irq[3] with trap_ret in TRAP: return first, re-enter one cycle later.
        ecall = 1'b1;
        expect_trap(32'd11, 8'h00);
        step();
        ecall = 1'b0;
        check("t6_in_trap", flags(), 64'b110);
        irq      = 8'h08;
        trap_ret = 1'b1;
        step();
        trap_ret = 1'b0;
        check("t6_ret_wins", flags(), 64'b001);
        expect_trap(32'h8000_0013, 8'h08);
        step();
        check("t6_reentry", flags(), 64'b110);
        check("t6_mcause", 64'(mcause), 64'h8000_0013);

        // Edge seen mid-trap latches, then reset drops everything asynchronously.
        irq = 8'h01;
        step();
        irq = '0;
        check("t6_edge_in_trap", 64'(irq_pending), 64'h01);
        check("t6_still_trapping", flags(), 64'b100);
        @(negedge clk);
        #1;
        Rst = 1'b1;
        #1;
        check_all_zero("rst_async");
        step();
        Rst = 1'b0;
        step();
        check_all_zero("post_rst");

        check("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
